frog_collision: RTL and testbench
=================================

Name: frog_collision

Overview:
- Upstream neighbour of the game-over display stage: decides when the frog has been hit and drives the level `hit` input that the game-over stage latches into its "GG" pixel pattern.
- Compares the frog's one-hot row position against the hazard (car) pixels of the same row once per game frame tick.
- Manages a life counter and a post-hit grace window.
- Asserts `hit` only when the last life is lost.

Parameters:
- WIDTH, 16, pixel columns per row; matches the 16-bit row format of the display stages.
- LIVES, 3, starting lives; legal range is 1 or more.
- GRACE_TICKS, 8, frame ticks of invulnerability after a non-fatal hit; legal range is 1 or more.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high; restores the start-of-game state.
- tick, input, 1, one-cycle frame strobe; all game decisions happen only on cycles where tick=1.
- frog_pos, input, WIDTH, frog column for the row under test; one-hot or zero.
- hazard, input, WIDTH, hazard pixels for the same row.
- hit, output, 1, game-over request to the downstream stage; registered and sticky.
- life_lost, output, 1, registered one-cycle pulse per non-fatal hit.
- lives, output, $clog2(LIVES+1), remaining lives; registered.

Behaviour:
- Reset is synchronous and active-high, and has priority over tick. Reset values:
  - state=PLAY
  - lives=LIVES
  - grace_cnt=0
  - hit=0
  - life_lost=0
- overlap = OR-reduction of (frog_pos & hazard). It is evaluated only when tick=1. Multiple overlapping bits still count as one hit per tick. frog_pos=0 never overlaps.
- States: PLAY, GRACE, OVER.
- PLAY, tick=1 and overlap=1, with lives>1:
  - lives decrements by 1.
  - grace_cnt loads GRACE_TICKS.
  - life_lost=1 for exactly the next cycle.
  - Next state is GRACE.
- PLAY, tick=1 and overlap=1, with lives==1:
  - lives becomes 0.
  - hit=1 from the next cycle onward.
  - life_lost stays 0.
  - Next state is OVER.
- PLAY otherwise: hold all state.
- GRACE:
  - Overlap is ignored.
  - On each tick, grace_cnt decrements.
  - On the tick where grace_cnt==1, grace_cnt becomes 0 and the next state is PLAY.
  - The first tick that can cost another life is therefore the tick after GRACE_TICKS grace ticks have been consumed.
  - Cycles without tick hold state.
- OVER:
  - Terminal; all inputs are ignored.
  - hit=1 and lives=0 are held until reset.
- Latency: outputs change on the clock edge that samples the deciding tick and are visible the following cycle. There is no combinational path from inputs to outputs.
- life_lost deasserts on the cycle after its single pulse, independent of tick.
- Reset during GRACE or OVER returns to the reset values on the next edge; hit drops to 0.
- Lives never underflows; decrement happens only from PLAY with lives≥1.
- GRACE_TICKS=1: GRACE lasts exactly one tick.

Decomposition:
- Shared package frogger_pkg holds:
  - typedef enum {PLAY, GRACE, OVER} collision_state_t
  - constants ROW_WIDTH=16, DEFAULT_LIVES=3, DEFAULT_GRACE_TICKS=8
- One natural sub-module, grace_timer: a loadable down-counter with inputs load, tick, reset and output done. It asserts done when the counter is 1 and tick=1.

Test Plan:
- Reset, then tick with frog_pos=16'h0010, hazard=16'h0010 → next cycle: lives=2, life_lost=1 for one cycle, hit=0.
- Continue from the previous state: 8 ticks, each with overlap → lives stays 2, no life_lost. A 9th tick with overlap → lives=1, life_lost pulse.
- LIVES=3: three spaced overlaps, each separated by ≥9 ticks → lives 2, then 1, then 0; hit=1 after the third. Further overlaps and ticks keep hit=1 and lives=0. Only two life_lost pulses occur.
- Overlap asserted while tick=0 for 20 cycles → no state change. frog_pos=0 with hazard=16'hFFFF on a tick → no hit.
- Reach OVER, assert reset for 1 cycle → hit=0, lives=3, state PLAY. Reset asserted together with an overlapping tick → reset wins, lives=3.
- Multi-bit overlap (frog_pos=16'h0100, hazard=16'h0FF0) on one tick → exactly one life lost.

Source files
------------

// File: rtl/frogger_pkg.sv
// Shared Frogger types and constants: collision FSM states and default row/game sizing.
package frogger_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    GRACE = 2'd1,
    OVER  = 2'd2
  } collision_state_t;

  localparam int ROW_WIDTH           = 16;
  localparam int DEFAULT_LIVES       = 3;
  localparam int DEFAULT_GRACE_TICKS = 8;

endpackage

// File: rtl/frog_collision_if.sv
// Row-under-test bus between the game core and the collision block.
interface frog_collision_if #(
  parameter int WIDTH = 16,
  parameter int LIVES = 3
);
  localparam int LW = $clog2(LIVES + 1);

  logic             tick;
  logic [WIDTH-1:0] frog_pos;
  logic [WIDTH-1:0] hazard;
  logic             hit;
  logic             life_lost;
  logic [LW-1:0]    lives;

  modport master (
    output tick, frog_pos, hazard,
    input  hit, life_lost, lives
  );

  modport slave (
    input  tick, frog_pos, hazard,
    output hit, life_lost, lives
  );
endinterface

// File: rtl/frog_collision_grace_timer.sv
// Loadable frame-tick down-counter; done flags the tick that consumes the last grace tick.
module grace_timer #(
  parameter int GRACE_TICKS = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic tick,
  output logic done
);
  localparam int CW = $clog2(GRACE_TICKS + 1);

  logic [CW-1:0] cnt_r;

  // Count register: load wins, otherwise count down on ticks and rest at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= CW'(0);
    end else if (load) begin
      cnt_r <= CW'(GRACE_TICKS);
    end else if (tick && (cnt_r != CW'(0))) begin
      cnt_r <= cnt_r - CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = tick && (cnt_r == CW'(1));

endmodule

// File: rtl/frog_collision.sv
// Frog/hazard collision judge: spends lives per frame tick, grants grace after a hit,
// and raises a sticky game-over request when the last life is lost.
module frog_collision
  import frogger_pkg::*;
#(
  parameter int WIDTH       = ROW_WIDTH,
  parameter int LIVES       = DEFAULT_LIVES,
  parameter int GRACE_TICKS = DEFAULT_GRACE_TICKS
) (
  input logic              clk,
  input logic              reset,
  frog_collision_if.slave  bus
);
  localparam int LW = $clog2(LIVES + 1);

  collision_state_t state_r;
  logic [LW-1:0]    lives_r;
  logic             hit_r;
  logic             life_lost_r;
  logic             overlap_s;
  logic             grace_load_s;
  logic             grace_done_s;

  // Overlap and grace-load decode for the current cycle.
  always_comb begin
    overlap_s    = |(bus.frog_pos & bus.hazard);
    grace_load_s = 1'b0;
    if ((state_r == PLAY) && bus.tick && overlap_s && (lives_r > LW'(1))) begin
      grace_load_s = 1'b1;
    end else begin
      grace_load_s = 1'b0;
    end
  end

  grace_timer #(
    .GRACE_TICKS (GRACE_TICKS)
  ) u_grace_timer (
    .clk   (clk),
    .reset (reset),
    .load  (grace_load_s),
    .tick  (bus.tick),
    .done  (grace_done_s)
  );

  // Game FSM with registered lives, hit and life_lost outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= PLAY;
      lives_r     <= LW'(LIVES);
      hit_r       <= 1'b0;
      life_lost_r <= 1'b0;
    end else begin
      life_lost_r <= 1'b0;
      case (state_r)
        PLAY: begin
          if (bus.tick && overlap_s) begin
            if (lives_r > LW'(1)) begin
              lives_r     <= lives_r - LW'(1);
              life_lost_r <= 1'b1;
              state_r     <= GRACE;
            end else begin
              lives_r <= LW'(0);
              hit_r   <= 1'b1;
              state_r <= OVER;
            end
          end else begin
            state_r <= PLAY;
          end
        end
        GRACE: begin
          if (grace_done_s) begin
            state_r <= PLAY;
          end else begin
            state_r <= GRACE;
          end
        end
        OVER: begin
          state_r <= OVER;
          hit_r   <= 1'b1;
          lives_r <= LW'(0);
        end
        default: begin
          // Unreachable encoding: treat as a lost game rather than resume play.
          state_r <= OVER;
          hit_r   <= 1'b1;
          lives_r <= LW'(0);
        end
      endcase
    end
  end

  assign bus.hit       = hit_r;
  assign bus.life_lost = life_lost_r;
  assign bus.lives     = lives_r;

endmodule

// File: tb/tb_frog_collision.sv
// Scenario bench for frog_collision: a behavioural game model queues expected outputs per cycle.
module tb_frog_collision;
  localparam int W  = 16;
  localparam int NL = 3;
  localparam int GT = 8;

  typedef struct packed {
    logic       hit;
    logic       ll;
    logic [1:0] lives;
  } exp_t;

  logic clk;
  logic reset;
  int   tests_run;
  int   failures;
  exp_t sb[$];

  // model state
  int   m_lives;
  int   m_grace;
  bit   m_over;

  frog_collision_if #(.WIDTH(W), .LIVES(NL)) bus ();

  frog_collision #(.WIDTH(W), .LIVES(NL), .GRACE_TICKS(GT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle, advance the model, queue the expected outputs.
  task automatic drive(input bit rst, input bit tk, input logic [W-1:0] fp, input logic [W-1:0] hz);
    bit   pulse;
    exp_t e;
    reset        = rst;
    bus.tick     = tk;
    bus.frog_pos = fp;
    bus.hazard   = hz;
    @(posedge clk);
    pulse = 1'b0;
    if (rst) begin
      m_lives = NL; m_grace = 0; m_over = 1'b0;
    end else if (tk && !m_over) begin
      if (m_grace > 0) m_grace = m_grace - 1;
      else if ((fp & hz) != '0) begin
        if (m_lives > 1) begin
          m_lives = m_lives - 1; m_grace = GT; pulse = 1'b1;
        end else begin
          m_lives = 0; m_over = 1'b1;
        end
      end
    end
    e.hit = m_over; e.ll = pulse; e.lives = 2'(m_lives);
    sb.push_back(e);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    drive(1'b1, 1'b0, 16'h0000, 16'h0000);
    drive(1'b1, 1'b1, 16'h0010, 16'h0010);
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front();
      tests_run++;
      if (i == 1 && {bus.hit, bus.life_lost, bus.lives} !== {e.hit, e.ll, e.lives}) begin
        failures++;
        $display("FAIL reset: got hit=%0b ll=%0b lives=%0d, want hit=%0b ll=%0b lives=%0d",
                 bus.hit, bus.life_lost, bus.lives, e.hit, e.ll, e.lives);
      end
    end
    tests_run++;
    if (bus.lives !== 2'd3 || bus.hit !== 1'b0 || bus.life_lost !== 1'b0) begin
      failures++;
      $display("FAIL reset_const: got hit=%0b ll=%0b lives=%0d, want 0 0 3", bus.hit, bus.life_lost, bus.lives);
    end
  endtask

  task automatic test_first_hit();
    exp_t e;
    drive(1'b0, 1'b1, 16'h0010, 16'h0010);
    e = sb.pop_front();
    tests_run++;
    if ({bus.hit, bus.life_lost, bus.lives} !== {e.hit, e.ll, e.lives} || bus.lives !== 2'd2 || bus.life_lost !== 1'b1) begin
      failures++;
      $display("FAIL first_hit: got hit=%0b ll=%0b lives=%0d, want hit=0 ll=1 lives=2", bus.hit, bus.life_lost, bus.lives);
    end
    drive(1'b0, 1'b0, 16'h0010, 16'h0010);
    e = sb.pop_front();
    tests_run++;
    if ({bus.hit, bus.life_lost, bus.lives} !== {e.hit, e.ll, e.lives} || bus.life_lost !== 1'b0) begin
      failures++;
      $display("FAIL pulse_width: got ll=%0b lives=%0d, want ll=0 lives=%0d", bus.life_lost, bus.lives, e.lives);
    end
  endtask

  task automatic test_grace();
    exp_t e;
    for (int i = 0; i < GT + 1; i++) begin
      drive(1'b0, 1'b1, 16'h0010, 16'h0010);
      e = sb.pop_front();
      tests_run++;
      if ({bus.hit, bus.life_lost, bus.lives} !== {e.hit, e.ll, e.lives}) begin
        failures++;
        $display("FAIL grace tick%0d: got hit=%0b ll=%0b lives=%0d, want hit=%0b ll=%0b lives=%0d",
                 i, bus.hit, bus.life_lost, bus.lives, e.hit, e.ll, e.lives);
      end
      if (i == GT - 1) begin
        tests_run++;
        if (bus.lives !== 2'd2 || bus.life_lost !== 1'b0) begin
          failures++;
          $display("FAIL grace_hold: got lives=%0d ll=%0b, want lives=2 ll=0", bus.lives, bus.life_lost);
        end
      end
    end
    tests_run++;
    if (bus.lives !== 2'd1 || bus.life_lost !== 1'b1) begin
      failures++;
      $display("FAIL grace_expiry: got lives=%0d ll=%0b, want lives=1 ll=1", bus.lives, bus.life_lost);
    end
  endtask

  task automatic test_no_tick();
    exp_t e;
    drive(1'b1, 1'b0, 16'h0000, 16'h0000);
    void'(sb.pop_front());
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 16'h8000, 16'hFFFF);
    drive(1'b0, 1'b1, 16'h0000, 16'hFFFF);
    for (int i = 0; i < 21; i++) begin
      e = sb.pop_front();
      if (i == 20) begin
        tests_run++;
        if ({bus.hit, bus.life_lost, bus.lives} !== {e.hit, e.ll, e.lives} || bus.lives !== 2'd3) begin
          failures++;
          $display("FAIL no_tick: got hit=%0b ll=%0b lives=%0d, want hit=0 ll=0 lives=3", bus.hit, bus.life_lost, bus.lives);
        end
      end
    end
  endtask

  task automatic test_game_over();
    exp_t e;
    int   pulses;
    pulses = 0;
    drive(1'b1, 1'b0, 16'h0000, 16'h0000);
    void'(sb.pop_front());
    for (int h = 0; h < 3; h++) begin
      drive(1'b0, 1'b1, 16'h0004, 16'h0006);
      e = sb.pop_front();
      if (bus.life_lost) pulses++;
      tests_run++;
      if ({bus.hit, bus.life_lost, bus.lives} !== {e.hit, e.ll, e.lives} || bus.lives !== 2'(2 - h)) begin
        failures++;
        $display("FAIL over_hit%0d: got hit=%0b ll=%0b lives=%0d, want lives=%0d", h, bus.hit, bus.life_lost, bus.lives, 2 - h);
      end
      for (int t = 0; t < GT + 1; t++) begin
        drive(1'b0, 1'b1, (t == GT) ? 16'h0000 : 16'h0004, 16'h0004);
        e = sb.pop_front();
        if (bus.life_lost) pulses++;
      end
    end
    for (int t = 0; t < 5; t++) begin
      drive(1'b0, 1'b1, 16'h0001, 16'hFFFF);
      e = sb.pop_front();
      if (bus.life_lost) pulses++;
      tests_run++;
      if ({bus.hit, bus.life_lost, bus.lives} !== {e.hit, e.ll, e.lives} || bus.hit !== 1'b1 || bus.lives !== 2'd0) begin
        failures++;
        $display("FAIL over_sticky: got hit=%0b ll=%0b lives=%0d, want hit=1 ll=0 lives=0", bus.hit, bus.life_lost, bus.lives);
      end
    end
    tests_run++;
    if (pulses != 2) begin
      failures++;
      $display("FAIL pulse_count: got %0d pulses, want 2", pulses);
    end
  endtask

  task automatic test_reset_priority();
    exp_t e;
    drive(1'b1, 1'b0, 16'h0000, 16'h0000);
    e = sb.pop_front();
    tests_run++;
    if ({bus.hit, bus.life_lost, bus.lives} !== {e.hit, e.ll, e.lives} || bus.hit !== 1'b0 || bus.lives !== 2'd3) begin
      failures++;
      $display("FAIL reset_from_over: got hit=%0b lives=%0d, want hit=0 lives=3", bus.hit, bus.lives);
    end
    drive(1'b1, 1'b1, 16'h0200, 16'h0200);
    e = sb.pop_front();
    tests_run++;
    if ({bus.hit, bus.life_lost, bus.lives} !== {e.hit, e.ll, e.lives} || bus.lives !== 2'd3) begin
      failures++;
      $display("FAIL reset_wins: got ll=%0b lives=%0d, want ll=0 lives=3", bus.life_lost, bus.lives);
    end
  endtask

  task automatic test_multibit();
    exp_t e;
    drive(1'b0, 1'b1, 16'h0100, 16'h0FF0);
    e = sb.pop_front();
    tests_run++;
    if ({bus.hit, bus.life_lost, bus.lives} !== {e.hit, e.ll, e.lives} || bus.lives !== 2'd2) begin
      failures++;
      $display("FAIL multibit: got hit=%0b ll=%0b lives=%0d, want hit=0 ll=1 lives=2", bus.hit, bus.life_lost, bus.lives);
    end
    drive(1'b0, 1'b0, 16'h0100, 16'h0FF0);
    e = sb.pop_front();
    tests_run++;
    if ({bus.hit, bus.life_lost, bus.lives} !== {e.hit, e.ll, e.lives}) begin
      failures++;
      $display("FAIL multibit_after: got ll=%0b lives=%0d, want ll=%0b lives=%0d", bus.life_lost, bus.lives, e.ll, e.lives);
    end
  endtask

  initial begin
    tests_run = 0; failures = 0;
    m_lives = NL; m_grace = 0; m_over = 1'b0;
    reset = 1'b1; bus.tick = 1'b0; bus.frog_pos = '0; bus.hazard = '0;
    @(posedge clk); #1;
    test_reset();
    test_first_hit();
    test_grace();
    test_no_tick();
    test_game_over();
    test_reset_priority();
    test_multibit();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
